// File: rtl/dma_bus_arbiter.sv
// CPU-side bus arbiter for a DMA BR/BG handshake: drains the CPU, grants the bus, steers mem_*.
// Optional saturating stall counter is built only when DMA_STALL_COUNT_EN is defined.
module dma_bus_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic                 cpu_busy,
  output logic                 cpu_stall,
  input  logic                 BR,
  output logic                 BG,
  input  logic                 dma_use_bus,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic                 dma_irq,
  input  logic                 irq_ack,
  output logic                 irq_pending,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     stall_count,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_bg;
  logic   r_irq_pending;
  logic   r_bus_err;

  // Handshake: DMA holds BR high for as long as it wants the bus; BG rises only once the
  // CPU has no access in flight, and falls one cycle after BR is seen low.
  always_comb begin
    w_next    = r_state;
    cpu_stall = 1'b0;
    mem_req   = cpu_req;
    mem_we    = cpu_we;
    mem_addr  = cpu_addr;
    case (r_state)
      S_IDLE: begin
        if (BR) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b0;
        if (!BR)            w_next = S_IDLE;
        else if (!cpu_busy) w_next = S_GRANT;
      end
      S_GRANT: begin
        cpu_stall = 1'b1;
        mem_req   = dma_use_bus;
        mem_we    = dma_use_bus;
        mem_addr  = dma_addr;
        if (!BR) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bg    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_bg    <= (w_next == S_GRANT);
    end
  end

  // Interrupt set wins over a same-cycle acknowledge so no completion is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_pending <= 1'b0;
    end else if (dma_irq) begin
      r_irq_pending <= 1'b1;
    end else if (irq_ack) begin
      r_irq_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (dma_use_bus && (r_state != S_GRANT)) begin
      r_bus_err <= 1'b1;
    end
  end

`ifdef DMA_STALL_COUNT_EN
  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (cpu_stall && cpu_req && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

  assign BG          = r_bg;
  assign irq_pending = r_irq_pending;
  assign bus_err     = r_bus_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: vector table, hand-written multi-cycle sequences and a
// randomized run checked against a behavioural ownership model.
module tb_dma_bus_arbiter;

  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_busy;
  logic [W-1:0]  cpu_addr;
  logic          cpu_stall;
  logic          BR, BG;
  logic          dma_use_bus;
  logic [W-1:0]  dma_addr;
  logic          dma_irq, irq_ack, irq_pending;
  logic          mem_req, mem_we;
  logic [W-1:0]  mem_addr;
  logic          bus_err;
  logic [CW-1:0] stall_count;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  dma_bus_arbiter #(.WORD_SIZE(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_busy(cpu_busy),
    .cpu_stall(cpu_stall), .BR(BR), .BG(BG),
    .dma_use_bus(dma_use_bus), .dma_addr(dma_addr),
    .dma_irq(dma_irq), .irq_ack(irq_ack), .irq_pending(irq_pending),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .bus_err(bus_err), .stall_count(stall_count), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_busy = 1'b0;
    BR = 1'b0; dma_use_bus = 1'b0; dma_addr = '0; dma_irq = 1'b0; irq_ack = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic br, busy, creq, cwe;
    logic [W-1:0] caddr;
    logic duse;
    logic [W-1:0] daddr;
    logic irq, ack;
    logic e_bg, e_stall, e_mreq, e_mwe;
    logic [W-1:0] e_maddr;
    logic e_ipend, e_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic br, logic busy, logic cwe, logic duse, logic [W-1:0] daddr,
                              logic irq, logic ack, logic e_bg, logic e_stall, logic e_mreq,
                              logic e_mwe, logic [W-1:0] e_maddr, logic e_ipend);
    vec_t v;
    v.br = br; v.busy = busy; v.creq = 1'b1; v.cwe = cwe; v.caddr = 16'h0040;
    v.duse = duse; v.daddr = daddr; v.irq = irq; v.ack = ack;
    v.e_bg = e_bg; v.e_stall = e_stall; v.e_mreq = e_mreq; v.e_mwe = e_mwe;
    v.e_maddr = e_maddr; v.e_ipend = e_ipend; v.e_err = 1'b0;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks who owns the bus: waiting for the CPU to finish, DMA holding the grant,
  // or the single turnaround cycle after the grant is returned.
  bit     m_wait, m_grant, m_turn, m_irq, m_err;
  longint m_cnt;

  task automatic model_reset();
    m_wait = 0; m_grant = 0; m_turn = 0; m_irq = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_check();
    logic e_stall, e_req, e_we;
    logic [W-1:0] e_addr;
    longint e_cnt;
    e_stall = m_wait || m_grant || m_turn;
    if (m_grant) begin
      e_req = dma_use_bus; e_we = dma_use_bus; e_addr = dma_addr;
    end else if (m_wait) begin
      e_req = 1'b0; e_we = cpu_we; e_addr = cpu_addr;
    end else if (m_turn) begin
      e_req = 1'b0; e_we = 1'b0; e_addr = cpu_addr;
    end else begin
      e_req = cpu_req; e_we = cpu_we; e_addr = cpu_addr;
    end
`ifdef DMA_STALL_COUNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 0;
`endif
    chk("rnd_bg", BG, m_grant);
    chk("rnd_stall", cpu_stall, e_stall);
    chk("rnd_mem_req", mem_req, e_req);
    chk("rnd_mem_we", mem_we, e_we);
    chk("rnd_mem_addr", mem_addr, e_addr);
    chk("rnd_irq_pending", irq_pending, m_irq);
    chk("rnd_bus_err", bus_err, m_err);
    chk("rnd_stall_count", stall_count, e_cnt[31:0]);
  endtask

  task automatic model_step();
    bit stalled;
    stalled = m_wait || m_grant || m_turn;
    if (dma_use_bus && !m_grant) m_err = 1;
    if (stalled && cpu_req && m_cnt < (64'd1 << CW) - 1) m_cnt++;
    if (dma_irq) m_irq = 1;
    else if (irq_ack) m_irq = 0;
    if (m_turn) begin
      m_turn = 0;
    end else if (m_grant) begin
      if (!BR) begin m_grant = 0; m_turn = 1; end
    end else if (m_wait) begin
      if (!BR) m_wait = 0;
      else if (!cpu_busy) begin m_wait = 0; m_grant = 1; end
    end else if (BR) begin
      m_wait = 1;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int n_pulses;
    logic [W-1:0] nxt;
    logic [31:0]  exp_cnt;

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_bg", BG, 0);
    chk("rst_irq_pending", irq_pending, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_req", mem_req, 1);
    chk("rst_mem_addr", mem_addr, 16'h0040);
    next_cycle();

    // table: grant, two DMA cycles, release, irq set/ack, withdrawn request
    //              br busy cwe duse daddr     irq ack  bg st mrq mwe maddr     ipend
    vecs[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 0, 16'h0040, 0);
    vecs[1]  = mk(1, 0, 0, 0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h0040, 0);
    vecs[2]  = mk(1, 0, 0, 1, 16'h01F4, 0, 0,  1, 1, 1, 1, 16'h01F4, 0);
    vecs[3]  = mk(1, 0, 0, 0, 16'h01F5, 0, 0,  1, 1, 0, 0, 16'h01F5, 0);
    vecs[4]  = mk(0, 0, 0, 0, 16'h01F6, 0, 0,  1, 1, 0, 0, 16'h01F6, 0);
    vecs[5]  = mk(0, 0, 0, 0, 16'h01F7, 1, 0,  0, 1, 0, 0, 16'h0040, 0);
    vecs[6]  = mk(0, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 0, 16'h0040, 1);
    vecs[7]  = mk(0, 0, 0, 0, 16'h0000, 1, 1,  0, 0, 1, 0, 16'h0040, 1);
    vecs[8]  = mk(0, 0, 0, 0, 16'h0000, 0, 1,  0, 0, 1, 0, 16'h0040, 1);
    vecs[9]  = mk(0, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 0, 16'h0040, 0);
    vecs[10] = mk(1, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 0, 16'h0040, 0);
    vecs[11] = mk(0, 1, 1, 0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0040, 0);
    vecs[12] = mk(0, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 0, 16'h0040, 0);
    vecs[13] = mk(0, 0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 0, 16'h0040, 0);
    for (int i = 0; i < 14; i++) begin
      BR = vecs[i].br; cpu_busy = vecs[i].busy; cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; dma_use_bus = vecs[i].duse; dma_addr = vecs[i].daddr;
      dma_irq = vecs[i].irq; irq_ack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_bg", i), BG, vecs[i].e_bg);
      chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].e_stall);
      chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].e_mreq);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_mwe);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
      chk($sformatf("vec%0d_irq_pending", i), irq_pending, vecs[i].e_ipend);
      chk($sformatf("vec%0d_bus_err", i), bus_err, vecs[i].e_err);
      next_cycle();
    end
    dma_irq = 0; irq_ack = 0;

    // drain: cpu_busy held for 4 cycles delays the grant to cycle 5
    do_reset();
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      BR = 1'b1; cpu_busy = (c < 4); cpu_addr = 16'h0040;
      @(negedge clk);
      if (BG && lat < 0) lat = c;
      if (cpu_stall && !BG) chk($sformatf("drain_addr_c%0d", c), mem_addr, 16'h0040);
      if (lat >= 0) break;
      next_cycle();
    end
    chk("drain_latency", lat, 5);
    next_cycle();
    cpu_busy = 1'b0;

    // full burst: 12 single-cycle DMA writes, scoreboarded by address
    n_pulses = 0;
    for (int k = 0; k < 26; k++) begin
      dma_use_bus = (k < 24) && (k % 2 == 0);
      dma_addr = 16'h01F4 + 16'(k / 2);
      if (dma_use_bus) exp_q.push_back(dma_addr);
      @(negedge clk);
      if (mem_req || mem_we) begin
        n_pulses++;
        if (exp_q.size() > 0) begin
          nxt = exp_q.pop_front();
          chk("burst_addr", mem_addr, nxt);
          chk("burst_we", {mem_req, mem_we}, 2'b11);
        end else begin
          chk("burst_stray", {mem_req, mem_we}, 2'b00);
        end
      end
      next_cycle();
    end
    chk("burst_pulses", n_pulses, 12);
    chk("burst_left", exp_q.size(), 0);
    dma_use_bus = 1'b0;
    BR = 1'b0;
    @(negedge clk); chk("drop_bg_same", BG, 1);
    next_cycle();
    @(negedge clk); chk("drop_bg_low", BG, 0); chk("drop_stall_turn", cpu_stall, 1);
    next_cycle();
    dma_irq = 1'b1;
    @(negedge clk); chk("drop_stall_free", cpu_stall, 0); chk("irq_before", irq_pending, 0);
    next_cycle();
    dma_irq = 1'b0;
    @(negedge clk); chk("irq_set", irq_pending, 1);
    next_cycle();
    irq_ack = 1'b1;
    @(negedge clk); chk("irq_hold", irq_pending, 1);
    next_cycle();
    irq_ack = 1'b0;
    @(negedge clk); chk("irq_clear", irq_pending, 0);
    next_cycle();

    // violation in IDLE, then async reset in GRANT
    do_reset();
    cpu_req = 1'b0; dma_use_bus = 1'b1; dma_addr = 16'h1234; cpu_addr = 16'h0077;
    @(negedge clk);
    chk("viol_mem_req", mem_req, 0);
    chk("viol_mem_addr", mem_addr, 16'h0077);
    next_cycle();
    dma_use_bus = 1'b0; BR = 1'b1;
    @(negedge clk); chk("viol_bus_err", bus_err, 1);
    next_cycle();
    next_cycle();
    @(negedge clk); chk("pre_rst_bg", BG, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_bg", BG, 0);
    chk("async_rst_err", bus_err, 0);
    chk("async_rst_stall", cpu_stall, 0);
    next_cycle();
    reset = 1'b0; BR = 1'b0; cpu_req = 1'b1;

    // stall counter: 7 stalled request cycles in DRAIN
    do_reset();
    for (int c = 0; c < 8; c++) begin
      BR = 1'b1; cpu_busy = 1'b1; cpu_req = 1'b1;
      next_cycle();
    end
`ifdef DMA_STALL_COUNT_EN
    exp_cnt = 7;
`else
    exp_cnt = 0;
`endif
    @(negedge clk); chk("stall_count_7", stall_count, exp_cnt);
    next_cycle();

    // randomized run against the model
    do_reset();
    model_reset();
    BR = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) BR = ~BR;
      cpu_busy    = ($urandom_range(0, 2) == 0);
      cpu_req     = $urandom_range(0, 1);
      cpu_we      = $urandom_range(0, 1);
      cpu_addr    = 16'($urandom);
      dma_use_bus = ($urandom_range(0, 3) == 0) && (c > 1500 || m_grant);
      dma_addr    = 16'($urandom);
      dma_irq     = ($urandom_range(0, 15) == 0);
      irq_ack     = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      model_check();
      model_step();
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
